// File: rtl/posicionador_frota_pkg.sv
// Shared types for the fleet positioner: FSM states, ship type codes,
// per-type fleet quotas and the one-hot LED encoding of the state.
package posicionador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DIRECAO    = 3'd1,
        ST_ORIENTACAO = 3'd2,
        ST_DEF_X      = 3'd3,
        ST_DEF_Y      = 3'd4,
        ST_VALIDA     = 3'd5,
        ST_ARMAZENA   = 3'd6,
        ST_PRONTO     = 3'd7
    } estado_t;

    localparam logic [2:0] TIPO_0    = 3'd0;
    localparam logic [2:0] TIPO_1    = 3'd1;
    localparam logic [2:0] TIPO_2    = 3'd2;
    localparam logic [2:0] TIPO_3    = 3'd3;
    localparam logic [2:0] TIPO_ULT  = 3'd4;

    // Number of ships of each type in one fleet (5,2,2,1,1).
    function automatic logic [2:0] quota(input logic [2:0] tipo);
        case (tipo)
            TIPO_0:   quota = 3'd5;
            TIPO_1:   quota = 3'd2;
            TIPO_2:   quota = 3'd2;
            TIPO_3:   quota = 3'd1;
            TIPO_ULT: quota = 3'd1;
            default:  quota = 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] estado_onehot(input estado_t st);
        estado_onehot = 8'd1 << st;
    endfunction

endpackage

// File: rtl/posicionador_frota_if.sv
// Validator handshake and board-memory write bus of the fleet positioner.
interface posicionador_frota_if #(
    parameter int COORD_W = 4,
    parameter int JOG_W   = 1
);
    logic               valida;
    logic               val_done;
    logic               conflito;
    logic               gravar;
    logic [2:0]         tipo;
    logic [JOG_W-1:0]   jogador;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               direcao;
    logic [2:0]         orientacao;

    modport master (
        output valida, gravar, tipo, jogador, x, y, direcao, orientacao,
        input  val_done, conflito
    );

    modport slave (
        input  valida, gravar, tipo, jogador, x, y, direcao, orientacao,
        output val_done, conflito
    );
endinterface

// File: rtl/posicionador_frota_detector_borda.sv
// Two-flop synchronizer for an active-low pushbutton plus a registered
// one-cycle pulse on each synchronized press (1->0 transition).
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic botao,
    output logic pulso
);
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_pulso;

    // The chain keeps sampling while disabled so presses made then are dropped, not deferred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_pulso <= 1'b0;
        end else begin
            r_s1    <= botao;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pulso <= enable & r_s3 & ~r_s2;
        end
    end

    assign pulso = r_pulso;
endmodule

// File: rtl/posicionador_frota.sv
// Fleet placement controller: walks each ship through direction, orientation
// and bow coordinates, asks the validator, and strobes accepted ships to memory.
module posicionador_frota
    import posicionador_pkg::*;
#(
    parameter int BOARD_N     = 10,
    parameter int COORD_W     = 4,
    parameter int N_ORIENT    = 5,
    parameter int N_JOGADORES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic enter,
    input  logic select,
    input  logic mode,
    posicionador_frota_if.master bus,
    output logic       ready,
    output logic [7:0] estado
);
    localparam int JOG_W = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;

    logic w_enter;
    logic w_select;

    estado_t            r_st;
    logic [7:0]         r_estado;
    logic               r_valida;
    logic               r_gravar;
    logic               r_ready;
    logic [2:0]         r_tipo;
    logic [2:0]         r_cnt;
    logic [JOG_W-1:0]   r_jog;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_dir;
    logic [2:0]         r_orient;

    detector_borda u_det_enter (
        .clk(clk), .reset(reset), .enable(enable), .botao(enter), .pulso(w_enter)
    );

    detector_borda u_det_select (
        .clk(clk), .reset(reset), .enable(enable), .botao(select), .pulso(w_select)
    );

    // Placement FSM; enter takes priority over select, every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st     <= ST_IDLE;
            r_estado <= 8'b0000_0001;
            r_valida <= 1'b0;
            r_gravar <= 1'b0;
            r_ready  <= 1'b0;
            r_tipo   <= TIPO_0;
            r_cnt    <= 3'd0;
            r_jog    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= 1'b0;
            r_orient <= 3'd0;
        end else if (enable) begin
            r_gravar <= 1'b0;
            case (r_st)
                ST_IDLE: begin
                    r_st     <= ST_DIRECAO;
                    r_estado <= estado_onehot(ST_DIRECAO);
                end
                ST_DIRECAO: begin
                    if (w_enter) begin
                        r_st     <= ST_ORIENTACAO;
                        r_estado <= estado_onehot(ST_ORIENTACAO);
                    end else if (w_select) begin
                        r_dir <= ~r_dir;
                    end
                end
                ST_ORIENTACAO: begin
                    if (w_enter) begin
                        r_st     <= ST_DEF_X;
                        r_estado <= estado_onehot(ST_DEF_X);
                    end else if (w_select) begin
                        r_orient <= (r_orient == 3'(N_ORIENT - 1)) ? 3'd0 : r_orient + 3'd1;
                    end
                end
                ST_DEF_X: begin
                    if (w_enter) begin
                        r_st     <= ST_DEF_Y;
                        r_estado <= estado_onehot(ST_DEF_Y);
                    end else if (w_select) begin
                        r_x <= (r_x == COORD_W'(BOARD_N - 1)) ? '0 : r_x + COORD_W'(1);
                    end
                end
                ST_DEF_Y: begin
                    if (w_enter) begin
                        r_st     <= ST_VALIDA;
                        r_estado <= estado_onehot(ST_VALIDA);
                        r_valida <= 1'b1;
                    end else if (w_select) begin
                        r_y <= (r_y == COORD_W'(BOARD_N - 1)) ? '0 : r_y + COORD_W'(1);
                    end
                end
                ST_VALIDA: begin
                    if (bus.val_done) begin
                        r_valida <= 1'b0;
                        if (bus.conflito) begin
                            r_st     <= ST_DEF_X;
                            r_estado <= estado_onehot(ST_DEF_X);
                        end else begin
                            r_st     <= ST_ARMAZENA;
                            r_estado <= estado_onehot(ST_ARMAZENA);
                            r_gravar <= 1'b1;
                        end
                    end
                end
                ST_ARMAZENA: begin
                    r_st     <= ST_DIRECAO;
                    r_estado <= estado_onehot(ST_DIRECAO);
                    if (r_cnt + 3'd1 == quota(r_tipo)) begin
                        r_cnt <= 3'd0;
                        if (r_tipo != TIPO_ULT) begin
                            r_tipo <= r_tipo + 3'd1;
                        end else if (!mode || r_jog == JOG_W'(N_JOGADORES - 1)) begin
                            r_st     <= ST_PRONTO;
                            r_estado <= estado_onehot(ST_PRONTO);
                            r_ready  <= 1'b1;
                        end else begin
                            r_jog  <= r_jog + JOG_W'(1);
                            r_tipo <= TIPO_0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_PRONTO: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_st     <= ST_IDLE;
                    r_estado <= estado_onehot(ST_IDLE);
                end
            endcase
        end
    end

    assign bus.valida     = r_valida;
    assign bus.gravar     = r_gravar;
    assign bus.tipo       = r_tipo;
    assign bus.jogador    = r_jog;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.direcao    = r_dir;
    assign bus.orientacao = r_orient;
    assign ready          = r_ready;
    assign estado         = r_estado;
endmodule
